// File: rtl/mem_pkg.sv
// Shared types and constants for the block memory arbiter.
// Holds default geometry, derived block constants, port ids and the sequencer state type.
package mem_pkg;

    localparam int MEM_ADDR_W      = 9;
    localparam int MEM_WORD_W      = 32;
    localparam int MEM_BLOCK_WORDS = 16;
    localparam int MEM_DEPTH_WORDS = 512;

    localparam int BLOCK_W        = MEM_WORD_W * MEM_BLOCK_WORDS;
    localparam int MAX_BLOCK_ADDR = MEM_DEPTH_WORDS - MEM_BLOCK_WORDS;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker.
// The last-granted pointer moves only on the update strobe, so a pick is stable while a command runs.
module rr_arb2
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       upd_port,
    output logic       valid,
    output logic       pick
);

    logic last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= PORT1;
        end else if (update) begin
            last <= upd_port;
        end
    end

    // On a tie the port that did not go last wins; port 0 wins the first tie after reset.
    always_comb begin
        valid = |req;
        pick  = PORT0;
        if (req[0] && req[1]) begin
            pick = ~last;
        end else if (req[1]) begin
            pick = PORT1;
        end
    end

endmodule

// File: rtl/block_mem_arbiter.sv
// Two-port round-robin sequencer in front of the shared block memory.
// Moves one 16-word block per command; out-of-range blocks complete with err and never touch the memory.
module block_mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int WORD_W      = MEM_WORD_W,
    parameter int BLOCK_WORDS = MEM_BLOCK_WORDS,
    parameter int MEM_DEPTH   = MEM_DEPTH_WORDS
)(
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          req0,
    input  logic                          wr0,
    input  logic [ADDR_W-1:0]             addr0,
    input  logic [WORD_W*BLOCK_WORDS-1:0] wdata0,
    input  logic                          req1,
    input  logic                          wr1,
    input  logic [ADDR_W-1:0]             addr1,
    input  logic [WORD_W*BLOCK_WORDS-1:0] wdata1,

    output logic                          gnt0,
    output logic                          gnt1,
    output logic                          done0,
    output logic                          done1,
    output logic                          err,
    output logic [WORD_W*BLOCK_WORDS-1:0] rdata,
    output logic                          busy,

    output logic [ADDR_W-1:0]             mem_address,
    output logic                          mem_we,
    output logic                          mem_oe,
    output logic [WORD_W*BLOCK_WORDS-1:0] mem_din,
    input  logic [WORD_W*BLOCK_WORDS-1:0] mem_dout
);

    localparam int                BW       = WORD_W * BLOCK_WORDS;
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_DEPTH - BLOCK_WORDS);

    state_t            state, state_nxt;

    logic              arb_valid, arb_pick;
    logic              latch;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [BW-1:0]     sel_wdata;
    logic              sel_oor;

    logic              port_q;
    logic              wr_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BW-1:0]     wdata_q;
    logic [BW-1:0]     rdata_q;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      ({req1, req0}),
        .update   (state == DONE),
        .upd_port (port_q),
        .valid    (arb_valid),
        .pick     (arb_pick)
    );

    always_comb begin
        sel_wr    = (arb_pick == PORT1) ? wr1    : wr0;
        sel_addr  = (arb_pick == PORT1) ? addr1  : addr0;
        sel_wdata = (arb_pick == PORT1) ? wdata1 : wdata0;
        sel_oor   = (sel_addr > MAX_ADDR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    latch     = 1'b1;
                    state_nxt = sel_oor ? DONE : ACCESS;
                end
            end
            ACCESS:  state_nxt = wr_q ? DONE : RESP;
            RESP:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A rejected command leaves the memory-facing registers untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            port_q  <= PORT0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (latch) begin
            port_q <= arb_pick;
            err_q  <= sel_oor;
            if (!sel_oor) begin
                wr_q    <= sel_wr;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
        end
    end

    // The memory read port is registered, so the block is on mem_dout during RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (state == RESP) begin
            rdata_q <= mem_dout;
        end
    end

    always_comb begin
        busy        = (state != IDLE);
        gnt0        = busy && (port_q == PORT0);
        gnt1        = busy && (port_q == PORT1);
        done0       = (state == DONE) && (port_q == PORT0);
        done1       = (state == DONE) && (port_q == PORT1);
        err         = (state == DONE) && err_q;
        mem_we      = (state == ACCESS) && wr_q;
        mem_oe      = (state == ACCESS) && !wr_q;
        mem_address = addr_q;
        mem_din     = wdata_q;
        rdata       = rdata_q;
    end

endmodule

// File: tb/tb_block_mem_arbiter.sv
// Directed bench for block_mem_arbiter with a behavioural 512x32 block memory.
// Expected values are hand-derived constants and known memory preload patterns.
module tb_block_mem_arbiter;

    localparam int AW = 9;
    localparam int BW = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [BW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, done0, done1, err, busy;
    logic [BW-1:0] rdata;
    logic [AW-1:0] mem_address;
    logic          mem_we, mem_oe;
    logic [BW-1:0] mem_din;
    logic [BW-1:0] mem_dout = '0;

    logic [31:0]   mem [0:511];
    int            n_vec = 0;
    int            n_miss = 0;
    int            done1_cnt = 0;

    always #5 clk = ~clk;

    block_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err(err), .rdata(rdata), .busy(busy),
        .mem_address(mem_address), .mem_we(mem_we), .mem_oe(mem_oe),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (int'(mem_address) + i < 512) begin
                if (mem_we) mem[int'(mem_address) + i] <= mem_din[i*32 +: 32];
                if (mem_oe) mem_dout[i*32 +: 32] <= mem[int'(mem_address) + i];
            end
        end
        if (done1) done1_cnt <= done1_cnt + 1;
    end

    function automatic logic [BW-1:0] mkblk(input logic [31:0] base);
        logic [BW-1:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = base + 32'(i);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    int d1_before;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h5000_0000 + 32'(i);
        do_reset();
        chk("rst_gnt", {gnt1, gnt0}, 2'b00);
        chk("rst_done", {done1, done0}, 2'b00);
        chk("rst_err_busy", {err, busy}, 2'b00);
        chk("rst_rdata", rdata, '0);
        chk("rst_mem_ctl", {mem_we, mem_oe}, 2'b00);
        chk("rst_mem_addr", mem_address, '0);
        chk("rst_mem_din", mem_din, '0);

        // Port 0 block write to 0x010
        req0 = 1'b1; wr0 = 1'b1; addr0 = 9'h010; wdata0 = mkblk(32'hA000_0000);
        step();
        chk("wr_access_gnt", {gnt1, gnt0, done0}, 3'b010);
        chk("wr_access_ctl", {mem_we, mem_oe}, 2'b10);
        chk("wr_access_addr", mem_address, 9'h010);
        chk("wr_access_din", mem_din, mkblk(32'hA000_0000));
        step();
        chk("wr_done", {done0, err, gnt0, mem_we}, 4'b1010);
        req0 = 1'b0;
        step();
        chk("wr_idle", {done0, busy, gnt0}, 3'b000);
        chk("wr_mem_lo", mem[9'h010], 32'hA000_0000);
        chk("wr_mem_hi", mem[9'h01F], 32'hA000_000F);

        // Read back 0x010: ACCESS, RESP, DONE
        req0 = 1'b1; wr0 = 1'b0; addr0 = 9'h010;
        step();
        chk("rd_access_ctl", {mem_we, mem_oe, gnt0}, 3'b011);
        step();
        chk("rd_resp", {done0, mem_we, mem_oe, busy}, 4'b0001);
        step();
        chk("rd_done", {done0, err}, 2'b10);
        chk("rd_data", rdata, mkblk(32'hA000_0000));
        req0 = 1'b0;
        step();

        // Tie arbitration after reset: 0,1,0,1 with both requests held
        do_reset();
        req0 = 1'b1; wr0 = 1'b1; addr0 = 9'h100; wdata0 = mkblk(32'hB000_0000);
        req1 = 1'b1; wr1 = 1'b1; addr1 = 9'h120; wdata1 = mkblk(32'hC000_0000);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_g;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            step();
            chk($sformatf("tie%0d_gnt", k), {gnt1, gnt0}, exp_g);
            step();
            chk($sformatf("tie%0d_done", k), {done1, done0}, exp_g);
            step();
            chk($sformatf("tie%0d_idle", k), {busy, gnt1, gnt0}, 3'b000);
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("tie_mem0", mem[9'h103], 32'hB000_0003);
        chk("tie_mem1", mem[9'h12F], 32'hC000_000F);

        // Port 1 read at the last legal block start
        req1 = 1'b1; wr1 = 1'b0; addr1 = 9'd496;
        step();
        chk("r496_access", {mem_oe, gnt1, gnt0}, 3'b110);
        chk("r496_addr", mem_address, 9'd496);
        step();
        step();
        chk("r496_done", {done1, err}, 2'b10);
        chk("r496_data", rdata, mkblk(32'h5000_01F0));
        req1 = 1'b0;
        step();

        // One past the last legal start: rejected immediately
        req1 = 1'b1; addr1 = 9'd497;
        step();
        chk("r497_done", {done1, err, gnt1}, 3'b111);
        chk("r497_mem_ctl", {mem_we, mem_oe}, 2'b00);
        req1 = 1'b0;
        step();
        chk("r497_idle", {done1, err, busy, mem_we, mem_oe}, 5'b00000);
        chk("r497_rdata_held", rdata, mkblk(32'h5000_01F0));

        // Req1 glitch while port 0 is busy is never served
        d1_before = done1_cnt;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 9'h010;
        step();
        req1 = 1'b1; wr1 = 1'b0; addr1 = 9'h040;
        step();
        req1 = 1'b0;
        step();
        chk("glitch_done0", {done0, done1}, 2'b10);
        chk("glitch_rdata", rdata, mkblk(32'hA000_0000));
        req0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("glitch_idle%0d", k), {gnt1, done1, busy}, 3'b000);
        end
        chk("glitch_done1_cnt", 512'(done1_cnt - d1_before), '0);

        // Reset asserted in RESP of a read
        req0 = 1'b1; wr0 = 1'b0; addr0 = 9'd496;
        step();
        step();
        chk("rr_in_resp", {busy, gnt0, mem_oe}, 3'b110);
        #2 rst = 1'b1;
        #1;
        chk("rr_async_ctl", {gnt0, gnt1, done0, done1, err, busy, mem_we, mem_oe}, 8'h00);
        chk("rr_async_rdata", rdata, '0);
        chk("rr_async_addr", mem_address, '0);
        req0 = 1'b0;
        #2 rst = 1'b0;
        step();
        chk("rr_after", {done0, busy}, 2'b00);
        req0 = 1'b1; wr0 = 1'b0; addr0 = 9'h010;
        step();
        step();
        step();
        chk("rr_reread_done", {done0, err}, 2'b10);
        chk("rr_reread_data", rdata, mkblk(32'hA000_0000));
        req0 = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
